// File: rtl/usb_tx_fifo_if.sv
// Byte-stream handshake between the host-side pusher, the USB TX packet engine and the TX FIFO.
// The master drives the strobes and write data; the slave (the FIFO) drives the head byte and status flags.
interface usb_tx_fifo_if;
    logic       clear;
    logic       store_tx_data;
    logic [7:0] tx_data;
    logic       get_tx_packet_data;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       full;
    logic       empty;
    logic       overflow_err;
    logic       underflow_err;

    modport master (
        output clear, store_tx_data, tx_data, get_tx_packet_data,
        input  tx_packet_data, buffer_occupancy, full, empty, overflow_err, underflow_err
    );

    modport slave (
        input  clear, store_tx_data, tx_data, get_tx_packet_data,
        output tx_packet_data, buffer_occupancy, full, empty, overflow_err, underflow_err
    );
endinterface

// File: rtl/usb_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the USB TX packet engine.
// Occupancy is tracked in a separate count so that full and empty stay distinct when wptr == rptr.
module usb_tx_fifo #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic           clk,
    input  logic           n_rst,
    usb_tx_fifo_if.slave   bus
);
    localparam logic [6:0] DEPTH_C = 7'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [6:0]        count_q, count_d;
    logic              overflow_err_q, overflow_err_d;
    logic              underflow_err_q, underflow_err_d;

    logic full_w, empty_w, push_ok, pop_ok, mem_we;

    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == 7'd0);
    // A push into a full buffer is still accepted when the same cycle frees a slot.
    assign push_ok = bus.store_tx_data && (!full_w || bus.get_tx_packet_data);
    assign pop_ok  = bus.get_tx_packet_data && !empty_w;
    assign mem_we  = push_ok && !bus.clear;

    always_comb begin
        wptr_d          = wptr_q;
        rptr_d          = rptr_q;
        count_d         = count_q;
        overflow_err_d  = 1'b0;
        underflow_err_d = 1'b0;
        if (bus.clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = 7'd0;
        end else begin
            if (push_ok) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_d = rptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + 7'd1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 7'd1;
            end
            overflow_err_d  = bus.store_tx_data && full_w && !bus.get_tx_packet_data;
            underflow_err_d = bus.get_tx_packet_data && empty_w;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            count_q         <= 7'd0;
            overflow_err_q  <= 1'b0;
            underflow_err_q <= 1'b0;
        end else begin
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            count_q         <= count_d;
            overflow_err_q  <= overflow_err_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    // Storage is not reset; its contents are never visible while the buffer is empty.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr_q] <= bus.tx_data;
        end
    end

    assign bus.tx_packet_data   = empty_w ? 8'h00 : mem[rptr_q];
    assign bus.buffer_occupancy = count_q;
    assign bus.full             = full_w;
    assign bus.empty            = empty_w;
    assign bus.overflow_err     = overflow_err_q;
    assign bus.underflow_err    = underflow_err_q;
endmodule

// File: tb/tb_usb_tx_fifo.sv
// Directed self-checking bench for usb_tx_fifo: a vector table plus hand-written
// sequences for fill/overflow, wrap, full push+pop, clear and asynchronous reset.
module tb_usb_tx_fifo;
    logic clk;
    logic n_rst;
    int   total;
    int   bad;

    usb_tx_fifo_if bus ();

    usb_tx_fifo #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       st;
        logic [7:0] d;
        logic       gt;
        int         occ;
        logic [7:0] head;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Drive one cycle of strobes, clock it, then sample 1 time unit after the edge.
    task automatic step(input logic clr, input logic st, input logic [7:0] d, input logic gt);
        bus.clear              = clr;
        bus.store_tx_data      = st;
        bus.tx_data            = d;
        bus.get_tx_packet_data = gt;
        @(posedge clk);
        #1;
        bus.clear              = 1'b0;
        bus.store_tx_data      = 1'b0;
        bus.tx_data            = 8'h00;
        bus.get_tx_packet_data = 1'b0;
    endtask

    task automatic chk_status(input string tag, input int occ, input logic [7:0] head,
                              input logic full, input logic empty, input logic ovf, input logic unf);
        chk({tag, ".occ"},   int'(bus.buffer_occupancy), occ);
        chk({tag, ".head"},  int'(bus.tx_packet_data),   int'(head));
        chk({tag, ".full"},  int'(bus.full),             int'(full));
        chk({tag, ".empty"}, int'(bus.empty),            int'(empty));
        chk({tag, ".ovf"},   int'(bus.overflow_err),     int'(ovf));
        chk({tag, ".unf"},   int'(bus.underflow_err),    int'(unf));
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.clear              = 1'b0;
        bus.store_tx_data      = 1'b0;
        bus.tx_data            = 8'h00;
        bus.get_tx_packet_data = 1'b0;

        //          clr   st    d      gt    occ head   full  empty ovf   unf
        tbl[0] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 8'h3C, 1'b0, 2, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'h01, 1'b0, 3, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 8'h5A, 1'b1, 1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

        do_reset();
        chk_status("reset", 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].clr, tbl[i].st, tbl[i].d, tbl[i].gt);
            $display("vec %0d: clr=%0b st=%0b d=%02h gt=%0b -> occ=%0d head=%02h ovf=%0b unf=%0b",
                     i, tbl[i].clr, tbl[i].st, tbl[i].d, tbl[i].gt,
                     bus.buffer_occupancy, bus.tx_packet_data, bus.overflow_err, bus.underflow_err);
            chk_status($sformatf("vec%0d", i), tbl[i].occ, tbl[i].head,
                       tbl[i].full, tbl[i].empty, tbl[i].ovf, tbl[i].unf);
        end

        // Fill with value = index, then overflow with 8'hFF.
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b0);
            chk($sformatf("fill%0d.occ", i), int'(bus.buffer_occupancy), i + 1);
        end
        $display("fill: occ=%0d full=%0b", bus.buffer_occupancy, bus.full);
        step(1'b0, 1'b1, 8'hFF, 1'b0);
        $display("overflow push: occ=%0d ovf=%0b", bus.buffer_occupancy, bus.overflow_err);
        chk_status("ovf", 64, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("ovf_pulse_end", int'(bus.overflow_err), 0);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("drain%0d.head", i), int'(bus.tx_packet_data), i);
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        $display("drain: occ=%0d empty=%0b", bus.buffer_occupancy, bus.empty);
        chk_status("drained", 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Full buffer: push and pop in the same cycle.
        for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        step(1'b0, 1'b1, 8'h77, 1'b1);
        $display("full push+pop: occ=%0d head=%02h ovf=%0b", bus.buffer_occupancy, bus.tx_packet_data, bus.overflow_err);
        chk_status("fullpp", 64, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 64; i++) begin
            chk($sformatf("fullpp_drain%0d.head", i), int'(bus.tx_packet_data), i);
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        chk("fullpp_last.head", int'(bus.tx_packet_data), 8'h77);
        chk("fullpp_last.occ", int'(bus.buffer_occupancy), 1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk_status("fullpp_empty", 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Clear with simultaneous push and pop.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        chk("pre_clear.occ", int'(bus.buffer_occupancy), 10);
        step(1'b1, 1'b1, 8'hEE, 1'b1);
        $display("clear: occ=%0d empty=%0b ovf=%0b unf=%0b", bus.buffer_occupancy, bus.empty, bus.overflow_err, bus.underflow_err);
        chk_status("clear", 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h12, 1'b0);
        $display("post-clear push: occ=%0d head=%02h", bus.buffer_occupancy, bus.tx_packet_data);
        chk_status("post_clear", 1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset with data stored, asserted away from any clock edge.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
        chk("pre_areset.occ", int'(bus.buffer_occupancy), 5);
        #2;
        n_rst = 1'b0;
        #1;
        $display("async reset: occ=%0d empty=%0b head=%02h", bus.buffer_occupancy, bus.empty, bus.tx_packet_data);
        chk_status("areset", 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk_status("after_areset", 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/usb_tx_fifo.md
Name: usb_tx_fifo

Overview:
- Byte-wide, first-word-fall-through data buffer that sits directly upstream of the USB TX packet engine.
- The host/AHB side pushes payload bytes with store_tx_data.
- The TX engine pops one byte per get_tx_packet_data strobe and samples tx_packet_data.
- buffer_occupancy is routed to the TX engine's 7-bit packet-size input, so a data packet carries exactly the buffered byte count (0..64).

Parameters:
DEPTH, 64, number of byte entries; must be a power of two no greater than 64.
ADDR_W, 6, pointer width = log2(DEPTH).

Ports:
clk  input  1  system clock; all state updates on rising edge
n_rst  input  1  asynchronous active-low reset
clear  input  1  synchronous flush: empties buffer, resets pointers
store_tx_data  input  1  push strobe; tx_data written this cycle
tx_data  input  8  byte to push
get_tx_packet_data  input  1  pop strobe from TX engine
tx_packet_data  output  8  current head byte (FWFT); 8'h00 when empty
buffer_occupancy  output  7  bytes held, 0..DEPTH
full  output  1  buffer_occupancy == DEPTH
empty  output  1  buffer_occupancy == 0
overflow_err  output  1  one-cycle pulse: push dropped because full
underflow_err  output  1  one-cycle pulse: pop ignored because empty

Behaviour:
Reset (n_rst low, asynchronous):
- wptr = 0, rptr = 0, count = 0.
- tx_packet_data = 8'h00, buffer_occupancy = 0, full = 0, empty = 1, overflow_err = 0, underflow_err = 0.
- Storage array contents are not reset; they are unobservable while empty.
- Reset asserted mid-packet discards all data immediately.

Storage and pointers:
- Register array mem[DEPTH] of 8 bits.
- wptr and rptr are ADDR_W bits and wrap modulo DEPTH (63 -> 0).
- A separate 7-bit count register distinguishes full from empty.

Push:
- If store_tx_data && (!full || get_tx_packet_data): mem[wptr] <= tx_data, wptr++.
- If store_tx_data && full && !get_tx_packet_data: byte dropped, pointers unchanged, overflow_err = 1 next cycle.

Pop:
- If get_tx_packet_data && !empty: rptr++.
- If get_tx_packet_data && empty: ignored (including when a push occurs in the same cycle), underflow_err = 1 next cycle.

count update:
- Increments on an accepted push only.
- Decrements on an accepted pop only.
- Unchanged when both are accepted in the same cycle.
- Saturation is impossible by construction.

Simultaneous push and pop:
- When full: both accepted; count stays DEPTH. The written slot is the one being freed (wptr == rptr), and the pop reads the old value.
- When empty: the push is accepted, the pop is ignored, underflow_err pulses, and count becomes 1.

clear:
- Has priority over push and pop in the same cycle: pointers and count go to 0.
- No error pulses are generated in a clear cycle.

Outputs:
- tx_packet_data = empty ? 8'h00 : mem[rptr].
- It is combinational from registered state, so it is valid in the cycle after a push into an empty buffer (latency 1 clk) and updates in the cycle after a pop.
- buffer_occupancy, full and empty are derived from the registered count; they update one clk after the causing strobe.
- Error pulses are registered and last exactly one clk per offending cycle; back-to-back offending cycles give a continuous high.

Test Plan:
- Reset then idle -> empty=1, full=0, buffer_occupancy=0, tx_packet_data=8'h00. Assert n_rst low asynchronously with 5 bytes stored -> occupancy 0 immediately, no clk edge required.
- Push 8'hA5, 8'h3C, 8'h01 on consecutive clks; then pop three times -> occupancy 1,2,3 then 2,1,0. tx_packet_data shows A5, 3C, 01 in order, then 8'h00 and empty=1.
- Push 64 bytes (value = index), then push 8'hFF -> full=1, occupancy 64, overflow_err high for 1 clk, 8'hFF absent. Pop all 64 -> values 0..63 in order, crossing pointer wrap.
- With full, push 8'h77 and pop in the same clk -> occupancy stays 64, no overflow_err. Head advances to 1; after 63 more pops the last byte read is 8'h77.
- Empty buffer, pop alone -> underflow_err 1 clk, occupancy 0. Push 8'h5A with a simultaneous pop -> underflow_err pulses, occupancy 1, tx_packet_data=8'h5A.
- 10 bytes stored, assert clear with store_tx_data and get_tx_packet_data in the same clk -> occupancy 0, empty=1, no error pulse. The next push of 8'h12 appears as head.
